sine_tone_analyzer: RTL
=======================

Name: sine_tone_analyzer

Overview:
- Receive side of the sine generator path: consumes a strobed stream of signed sine samples.
- Measures signal period in clock cycles and peak-to-peak amplitude over each full cycle.
- Uses hysteresis-qualified rising zero crossings to find cycle boundaries.
- Feeds frequency/amplitude self-check logic and status registers; flags loss of signal via timeout.

Parameters:
- DATA_W, 16, sample width (signed two's complement)
- CNT_W, 32, width of the period counter and period output
- HYST, 1000, hysteresis threshold magnitude (positive, < 2^(DATA_W-1))
- MAX_PERIOD, 1000000, clock cycles without a completed crossing before timeout (< 2^CNT_W)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- sample_valid  in  1  one-cycle strobe qualifying sample
- sample  in  DATA_W  signed input sample
- period  out  CNT_W  clock cycles between the last two qualified rising crossings
- p2p  out  DATA_W+1  unsigned max−min of samples over the last measured cycle
- meas_valid  out  1  one-cycle pulse when period/p2p update
- locked  out  1  at least one measurement since the last reset/timeout
- no_signal  out  1  sticky timeout flag, cleared by next measurement

Behaviour:
- Reset (async, immediate): period=0, p2p=0, meas_valid=0, locked=0, no_signal=0, FSM=SEEK, counter=0, max/min trackers cleared.
- Samples are evaluated only in cycles with sample_valid=1. Comparisons are signed.
  - "low": sample <= −HYST.
  - "high": sample >= +HYST.
- FSM states:
  - SEEK: on a low sample → ARM. Counter idle.
  - ARM: on a high sample (start crossing) → HIGH; counter<=1; max=min=sample.
  - HIGH: update max/min on every valid sample; on a low sample → LOW.
  - LOW: update max/min.
    - On a high sample (end crossing): period<=counter; p2p<=max−min computed over samples before this one; meas_valid=1 next cycle; locked<=1; no_signal<=0.
    - Then counter<=1, max=min=current sample, stay cycle-continuous → HIGH.
- Counter: in HIGH/LOW it increments by 1 every clk, not just valid cycles. For crossing strobes at cycles t0 and t1, period = t1−t0.
- Output latency: outputs are registered and valid the cycle after the crossing strobe. meas_valid is high for exactly one cycle.
- Timeout: in HIGH or LOW with counter == MAX_PERIOD and no end crossing this cycle:
  - no_signal<=1, locked<=0, FSM→SEEK, counter<=0.
  - period and p2p hold their last values; no meas_valid.
- Simultaneous events: an end crossing in the same cycle counter == MAX_PERIOD is a valid measurement (period=MAX_PERIOD); it is not a timeout.
- Counter never wraps; the timeout bounds it.
- Samples strictly between −HYST and +HYST never cause a transition but still update max/min in HIGH/LOW.
- In ARM, repeated low samples keep ARM. In HIGH, repeated high samples keep HIGH.
- p2p arithmetic: max−min at DATA_W+1 bits, no overflow. For DATA_W=16 the range is 0..65535.
- Reset asserted mid-measurement discards the partial cycle. The first measurement after reset needs two full rising crossings.
- sample_valid=0: sample is ignored entirely; the counter still runs.

Test Plan:
- Ideal sine, amplitude 32000, 64 samples/cycle, sample_valid every 156 clks → from the second crossing, meas_valid pulses once per cycle with period=9984, p2p=64000, locked=1, no_signal=0.
- Reset asserted for 3 cycles mid-cycle, then the same stimulus → all outputs 0 during reset. First meas_valid comes only after two rising crossings post-reset, with correct values.
- Amplitude 800 (<HYST) sine, MAX_PERIOD=20000 → FSM never leaves SEEK/ARM, no meas_valid, locked=0. no_signal stays 0 because there is no timeout outside HIGH/LOW.
- Locked 1 kHz signal, then input held at +5000 → exactly MAX_PERIOD cycles after the last crossing: no_signal=1, locked=0, period/p2p hold 9984/64000. Restoring the sine gives a new measurement and no_signal=0.
- Crafted stream: −2000 at t, +2000 at t+10, −2000 at t+20, +2000 at t+10+MAX_PERIOD → meas_valid with period=MAX_PERIOD, p2p=4000, no timeout.
- Noisy sine with ±900 glitches around zero (|glitch|<HYST) → exactly one meas_valid per true cycle, period unchanged from the clean case.

Source files
------------

// File: rtl/sine_tone_analyzer.sv
// Receive-side tone analyzer: measures period (clk cycles) and peak-to-peak
// amplitude of a strobed signed sine stream using hysteresis-qualified rising crossings.
module sine_tone_analyzer #(
    parameter int DATA_W     = 16,
    parameter int CNT_W      = 32,
    parameter int HYST       = 1000,
    parameter int MAX_PERIOD = 1000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample,
    output logic [CNT_W-1:0]         period,
    output logic [DATA_W:0]          p2p,
    output logic                     meas_valid,
    output logic                     locked,
    output logic                     no_signal
);

    typedef enum logic [1:0] {SEEK, ARM, HIGH, LOW} state_t;

    localparam logic signed [DATA_W-1:0] HYST_P  = DATA_W'(HYST);
    localparam logic signed [DATA_W-1:0] HYST_N  = -HYST_P;
    localparam logic [CNT_W-1:0]         MAX_CNT = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0]         CNT_ONE = CNT_W'(1);

    state_t                     state_reg, state_next;
    logic [CNT_W-1:0]           count_reg, count_next;
    logic [CNT_W-1:0]           period_reg, period_next;
    logic [DATA_W:0]            p2p_reg, p2p_next;
    logic signed [DATA_W-1:0]   max_reg, max_next;
    logic signed [DATA_W-1:0]   min_reg, min_next;
    logic                       meas_valid_reg, meas_valid_next;
    logic                       locked_reg, locked_next;
    logic                       no_signal_reg, no_signal_next;

    logic                       is_low;
    logic                       is_high;
    logic                       at_limit;
    logic                       end_crossing;
    logic                       timeout;
    logic signed [DATA_W-1:0]   trk_max;
    logic signed [DATA_W-1:0]   trk_min;
    logic [DATA_W:0]            span;

    assign is_low       = sample_valid && (sample <= HYST_N);
    assign is_high      = sample_valid && (sample >= HYST_P);
    assign at_limit     = (count_reg == MAX_CNT);
    assign end_crossing = (state_reg == LOW) && is_high;
    // A crossing landing exactly on the limit is still a measurement.
    assign timeout      = ((state_reg == HIGH) || (state_reg == LOW)) && at_limit && !end_crossing;

    assign trk_max = (sample > max_reg) ? sample : max_reg;
    assign trk_min = (sample < min_reg) ? sample : min_reg;
    // One extra bit so the full signed range difference cannot overflow.
    assign span    = {max_reg[DATA_W-1], max_reg} - {min_reg[DATA_W-1], min_reg};

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        period_next     = period_reg;
        p2p_next        = p2p_reg;
        max_next        = max_reg;
        min_next        = min_reg;
        meas_valid_next = 1'b0;
        locked_next     = locked_reg;
        no_signal_next  = no_signal_reg;

        case (state_reg)
            SEEK: begin
                count_next = '0;
                if (is_low) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                count_next = '0;
                if (is_high) begin
                    state_next = HIGH;
                    count_next = CNT_ONE;
                    max_next   = sample;
                    min_next   = sample;
                end
            end
            HIGH: begin
                count_next = count_reg + CNT_ONE;
                if (sample_valid) begin
                    max_next = trk_max;
                    min_next = trk_min;
                end
                if (is_low) begin
                    state_next = LOW;
                end
            end
            LOW: begin
                if (is_high) begin
                    // Crossing sample opens the next cycle, so it is excluded from this span.
                    period_next     = count_reg;
                    p2p_next        = span;
                    meas_valid_next = 1'b1;
                    locked_next     = 1'b1;
                    no_signal_next  = 1'b0;
                    count_next      = CNT_ONE;
                    max_next        = sample;
                    min_next        = sample;
                    state_next      = HIGH;
                end else begin
                    count_next = count_reg + CNT_ONE;
                    if (sample_valid) begin
                        max_next = trk_max;
                        min_next = trk_min;
                    end
                end
            end
            default: begin
                state_next = SEEK;
                count_next = '0;
            end
        endcase

        if (timeout) begin
            state_next     = SEEK;
            count_next     = '0;
            locked_next    = 1'b0;
            no_signal_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= SEEK;
            count_reg      <= '0;
            period_reg     <= '0;
            p2p_reg        <= '0;
            max_reg        <= '0;
            min_reg        <= '0;
            meas_valid_reg <= 1'b0;
            locked_reg     <= 1'b0;
            no_signal_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            period_reg     <= period_next;
            p2p_reg        <= p2p_next;
            max_reg        <= max_next;
            min_reg        <= min_next;
            meas_valid_reg <= meas_valid_next;
            locked_reg     <= locked_next;
            no_signal_reg  <= no_signal_next;
        end
    end

    assign period     = period_reg;
    assign p2p        = p2p_reg;
    assign meas_valid = meas_valid_reg;
    assign locked     = locked_reg;
    assign no_signal  = no_signal_reg;

endmodule
